acl_int_event_capture: RTL and testbench

//  Consumes the debounced ACL interrupt level and turns each rising edge into one

---
 rtl/acl_int_event_capture.sv | 96 +++++++++
 tb/tb_acl_int_event_capture.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/acl_int_event_capture.sv
// Turns rising edges of the debounced ACL interrupt into req/ack events for the SPI driver,
// with a post-ack hold-off window, edge latching during hold-off, an edge counter and overrun flag.
module acl_int_event_capture #(
  parameter int HOLDOFF_CYCLES = 200,
  parameter int COUNT_BITS     = 8
) (
  input  logic                  i_clk_20mhz,
  input  logic                  i_rst_20mhz,
  input  logic                  i_int_deb,
  input  logic                  i_enable,
  input  logic                  i_ack,
  input  logic                  i_clr_ovr,
  output logic                  o_req,
  output logic                  o_holdoff,
  output logic                  o_overrun,
  output logic [COUNT_BITS-1:0] o_event_count
);

  // Handshake: o_req is a level that rises one clock after an accepted edge and
  // stays high until the driver returns a one-cycle i_ack while o_req is high.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = (HOLDOFF_CYCLES > 0) ? 16'(HOLDOFF_CYCLES - 1) : 16'd0;

  state_t      state;
  logic [15:0] timer;
  logic        pending;
  logic        s_prev;
  logic        rise;
  logic        acc;
  logic        set_ovr;

  assign rise    = i_int_deb & ~s_prev;
  assign acc     = rise & i_enable;
  assign set_ovr = (state == ST_REQ) & acc & ~i_ack;

  assign o_req     = (state == ST_REQ);
  assign o_holdoff = (state == ST_HOLD);

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state         <= ST_IDLE;
      timer         <= 16'd0;
      pending       <= 1'b0;
      s_prev        <= 1'b0;
      o_overrun     <= 1'b0;
      o_event_count <= '0;
    end else begin
      s_prev <= i_int_deb;
      if (acc) o_event_count <= o_event_count + 1'b1;

      // A new overrun in the same cycle as a clear request keeps the flag set.
      if (set_ovr)        o_overrun <= 1'b1;
      else if (i_clr_ovr) o_overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (acc) begin
            state <= ST_REQ;
            timer <= 16'd0;
          end
        end
        ST_REQ: begin
          if (i_ack) begin
            timer <= 16'd0;
            if (HOLDOFF_CYCLES > 0) begin
              state   <= ST_HOLD;
              pending <= acc;
            end else begin
              state <= acc ? ST_REQ : ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          timer <= timer + 16'd1;
          if (acc) pending <= 1'b1;
          if (timer == HOLD_LAST) begin
            state   <= (pending | acc) ? ST_REQ : ST_IDLE;
            pending <= 1'b0;
            timer   <= 16'd0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          timer   <= 16'd0;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acl_int_event_capture.sv
// Directed bench for acl_int_event_capture: a 200-cycle hold-off instance and a no-hold-off instance.
module tb_acl_int_event_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_deb, en, ack, clr;
  logic       req, hold, ovr;
  logic [7:0] cnt;
  logic       int0, en0, ack0, clr0;
  logic       req0, hold0, ovr0;
  logic [7:0] cnt0;

  int n_checks = 0;
  int n_fail   = 0;
  int hold_cycles;

  always #25 clk = ~clk;

  acl_int_event_capture #(.HOLDOFF_CYCLES(200), .COUNT_BITS(8)) dut (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_int_deb(int_deb), .i_enable(en),
    .i_ack(ack), .i_clr_ovr(clr), .o_req(req), .o_holdoff(hold),
    .o_overrun(ovr), .o_event_count(cnt)
  );

  acl_int_event_capture #(.HOLDOFF_CYCLES(0), .COUNT_BITS(8)) dut0 (
    .i_clk_20mhz(clk), .i_rst_20mhz(rst), .i_int_deb(int0), .i_enable(en0),
    .i_ack(ack0), .i_clr_ovr(clr0), .o_req(req0), .o_holdoff(hold0),
    .o_overrun(ovr0), .o_event_count(cnt0)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_int();
    int_deb = 1'b1; tick();
    int_deb = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; int_deb = 1'b0; en = 1'b1; ack = 1'b0; clr = 1'b0;
    int0 = 1'b0; en0 = 1'b1; ack0 = 1'b0; clr0 = 1'b0;
    tick(); tick(); tick();
    check("rst_req", req, 1'b0);
    check("rst_hold", hold, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_cnt", cnt, 8'd0);
    rst = 1'b0;

    // Test 1: first edge, request one clock later
    for (int i = 0; i < 9; i++) tick();
    int_deb = 1'b1; tick();
    check("t1_req", req, 1'b1);
    check("t1_cnt", cnt, 8'd1);
    int_deb = 1'b0; tick();

    // Test 2: overrun, clear coincident with a new overrun
    int_deb = 1'b1; tick();
    check("t2_ovr", ovr, 1'b1);
    check("t2_cnt", cnt, 8'd2);
    check("t2_req", req, 1'b1);
    int_deb = 1'b0; tick();
    int_deb = 1'b1; clr = 1'b1; tick();
    check("t2_ovr_clr_race", ovr, 1'b1);
    check("t2_cnt3", cnt, 8'd3);
    int_deb = 1'b0; clr = 1'b0; tick();
    clr = 1'b1; tick();
    check("t2_ovr_cleared", ovr, 1'b0);
    clr = 1'b0;

    // Test 1/3: ack, 200-cycle hold-off with an edge at hold-off cycle 50
    ack = 1'b1; tick();
    ack = 1'b0;
    check("t3_req_after_ack", req, 1'b0);
    check("t3_hold_after_ack", hold, 1'b1);
    hold_cycles = 1;
    for (int i = 0; i < 300; i++) begin
      int_deb = (hold_cycles == 50);
      tick();
      if (hold) hold_cycles++;
      else break;
    end
    int_deb = 1'b0;
    check("t3_hold_len", hold_cycles, 200);
    check("t3_req_pending", req, 1'b1);
    check("t3_cnt", cnt, 8'd4);
    check("t3_no_ovr", ovr, 1'b0);

    // Hold-off with nothing pending returns to idle
    ack = 1'b1; tick();
    ack = 1'b0;
    hold_cycles = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (hold) hold_cycles++;
      else break;
    end
    check("t1_hold_len2", hold_cycles, 200);
    check("t1_idle_req", req, 1'b0);
    check("t1_idle_hold", hold, 1'b0);

    // Test 4: disabled edges ignored, ack in idle ignored
    en = 1'b0;
    for (int i = 0; i < 5; i++) pulse_int();
    check("t4_cnt", cnt, 8'd4);
    check("t4_req", req, 1'b0);
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    ack = 1'b1; tick();
    ack = 1'b0; tick();
    check("t4_ack_req", req, 1'b0);
    check("t4_ack_hold", hold, 1'b0);
    check("t4_ack_cnt", cnt, 8'd4);

    // Test 5: counter wrap
    en = 1'b1;
    for (int i = 0; i < 252; i++) pulse_int();
    check("t5_wrap0", cnt, 8'd0);
    for (int i = 0; i < 4; i++) pulse_int();
    check("t5_wrap4", cnt, 8'd4);
    check("t5_req", req, 1'b1);
    check("t5_ovr", ovr, 1'b1);

    // Test 6: reset mid-request, input high at release
    rst = 1'b1; int_deb = 1'b1; tick();
    check("t6_req", req, 1'b0);
    check("t6_ovr", ovr, 1'b0);
    check("t6_cnt", cnt, 8'd0);
    check("t6_hold", hold, 1'b0);
    rst = 1'b0; tick();
    check("t6_rel_req", req, 1'b1);
    check("t6_rel_cnt", cnt, 8'd1);
    int_deb = 1'b0;

    // Test 5b: no hold-off, ack with same-cycle edge
    int0 = 1'b1; tick();
    check("t5b_req", req0, 1'b1);
    check("t5b_cnt", cnt0, 8'd1);
    int0 = 1'b0; tick();
    int0 = 1'b1; ack0 = 1'b1; tick();
    check("t5b_req_stay", req0, 1'b1);
    check("t5b_no_ovr", ovr0, 1'b0);
    check("t5b_no_hold", hold0, 1'b0);
    check("t5b_cnt2", cnt0, 8'd2);
    int0 = 1'b0; ack0 = 1'b0; tick();
    ack0 = 1'b1; tick();
    ack0 = 1'b0;
    check("t5b_idle", req0, 1'b0);
    check("t5b_idle_hold", hold0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
